// File: rtl/tinyml_axis_arb_mux_pkg.sv
// Shared helpers for the packet-level AXI-Stream arbitrated multiplexer.
package tinyml_axis_arb_mux_pkg;

  // Index width for a port count; never narrower than one bit.
  function automatic int cl_count(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tinyml_axis_skid_reg.sv
// Registered output stage with one skid entry; o_ready is a register, so the
// downstream ready never reaches the upstream ready combinationally.
module tinyml_axis_skid_reg #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PAYLOAD_W-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [PAYLOAD_W-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t               r_state;
  logic [PAYLOAD_W-1:0] r_out_data;
  logic [PAYLOAD_W-1:0] r_temp_data;
  logic                 r_out_valid;
  logic                 r_ready_int;

  // i_valid means a beat was accepted this cycle; it only happens while r_ready_int is high,
  // which is never the case in S_FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_ready_int <= 1'b0;
    end else begin
      r_ready_int <= i_ready | ((r_state != S_FULL) & ((r_state == S_EMPTY) | ~i_valid));
      case (r_state)
        S_EMPTY: begin
          if (i_valid) begin
            r_out_data  <= i_data;
            r_out_valid <= 1'b1;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (i_valid && i_ready) begin
            r_out_data <= i_data;
          end else if (i_valid) begin
            r_temp_data <= i_data;
            r_state     <= S_FULL;
          end else if (i_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (i_ready) begin
            r_out_data <= r_temp_data;
            r_state    <= S_ONE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_EMPTY;
        end
      endcase
    end
  end

  assign o_ready = r_ready_int;
  assign o_data  = r_out_data;
  assign o_valid = r_out_valid;

endmodule

// File: rtl/tinyml_axis_arb_mux.sv
// Merges S_COUNT AXI-Stream inputs onto one output under an external
// acknowledge-mode arbiter, so a granted packet is never interleaved.
module tinyml_axis_arb_mux
  import tinyml_axis_arb_mux_pkg::*;
#(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int CL_S_COUNT = cl_count(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [CL_S_COUNT-1:0]         m_axis_tid,
  output logic [S_COUNT-1:0]            arb_request,
  output logic [S_COUNT-1:0]            arb_acknowledge,
  input  logic [S_COUNT-1:0]            arb_grant,
  input  logic                          arb_grant_valid,
  input  logic [CL_S_COUNT-1:0]         arb_grant_encoded
);

  localparam int PAYLOAD_W = DATA_WIDTH + KEEP_WIDTH + 1 + CL_S_COUNT;

  logic                  w_ready_int;
  logic [S_COUNT-1:0]    w_s_ready;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [KEEP_WIDTH-1:0] w_sel_keep;
  logic                  w_sel_last;
  logic                  w_sel_accept;
  logic [PAYLOAD_W-1:0]  w_in_payload;
  logic [PAYLOAD_W-1:0]  w_out_payload;

  assign w_s_ready       = {S_COUNT{arb_grant_valid & w_ready_int}} & arb_grant;
  assign s_axis_tready   = w_s_ready;
  assign arb_request     = s_axis_tvalid;
  assign arb_acknowledge = arb_grant & s_axis_tvalid & w_s_ready & s_axis_tlast;

  // Data path follows the encoded grant; the one-hot grant only gates readiness.
  always_comb begin
    w_sel_data   = '0;
    w_sel_keep   = '0;
    w_sel_last   = 1'b0;
    w_sel_accept = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (arb_grant_encoded == CL_S_COUNT'(i)) begin
        w_sel_data   = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_keep   = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        w_sel_last   = s_axis_tlast[i];
        w_sel_accept = s_axis_tvalid[i] & w_s_ready[i];
      end
    end
  end

  assign w_in_payload = {w_sel_data, w_sel_keep, w_sel_last, arb_grant_encoded};

  tinyml_axis_skid_reg #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_data  (w_in_payload),
    .i_valid (w_sel_accept),
    .o_ready (w_ready_int),
    .o_data  (w_out_payload),
    .o_valid (m_axis_tvalid),
    .i_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid} = w_out_payload;

endmodule

// File: doc/tinyml_axis_arb_mux.md
# tinyml_axis_arb_mux

Packet-level AXI-Stream multiplexer that merges S_COUNT input streams onto one output stream. It consumes the grant from an external arbiter run in BLOCK="ACKNOWLEDGE" mode, and returns request/acknowledge to that arbiter so that a granted packet is never interleaved. The selected beat goes through a registered output stage with a skid buffer, so there is no combinational path from m_axis_tready to any s_axis_tready.

## Interface
- S_COUNT, 4, number of input streams (≥2)
- DATA_WIDTH, 32, tdata width
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- CL_S_COUNT, $clog2(S_COUNT), width of grant index and m_axis_tid
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- s_axis_tdata  input  S_COUNT*DATA_WIDTH  per-port data, port i at slice i
- s_axis_tkeep  input  S_COUNT*KEEP_WIDTH  per-port byte enables
- s_axis_tvalid  input  S_COUNT  per-port valid
- s_axis_tready  output  S_COUNT  per-port ready
- s_axis_tlast  input  S_COUNT  per-port end of packet
- m_axis_tdata  output  DATA_WIDTH  merged data
- m_axis_tkeep  output  KEEP_WIDTH  merged byte enables
- m_axis_tvalid  output  1  output valid
- m_axis_tready  input  1  output ready
- m_axis_tlast  output  1  end of packet
- m_axis_tid  output  CL_S_COUNT  source port index of the beat
- arb_request  output  S_COUNT  request vector to the arbiter
- arb_acknowledge  output  S_COUNT  packet-complete acknowledge to the arbiter
- arb_grant  input  S_COUNT  one-hot grant from the arbiter (registered there)
- arb_grant_valid  input  1  grant valid
- arb_grant_encoded  input  CL_S_COUNT  binary grant index

## Operation
- Request: arb_request = s_axis_tvalid.
- Input accept: s_axis_tready[i] = arb_grant_valid & arb_grant[i] & ready_int_reg.
- Accepted beat: a beat is accepted when the selected port's tvalid and tready are both high.
- Acknowledge: arb_acknowledge[i] = arb_grant[i] & s_axis_tvalid[i] & s_axis_tready[i] & s_axis_tlast[i]. It is asserted only in the cycle the last beat is accepted.
- Data selection: the data mux is indexed by arb_grant_encoded.
- Beat carried to the output stage: tdata, tkeep, tlast, and tid = arb_grant_encoded.
- No grant: if arb_grant_valid = 0 or arb_grant = 0, every s_axis_tready is 0 and no beat is accepted.
- Output stage: one output register plus one skid (temp) register.
  - States: EMPTY (output invalid), ONE (output valid, skid empty), FULL (output and skid both valid).
  - ready_int_reg next = m_axis_tready | (skid empty & (output empty | no beat accepted this cycle)).
  - EMPTY + accepted beat → ONE.
  - ONE + accepted beat + !m_axis_tready → FULL.
  - ONE + !accepted beat + m_axis_tready → EMPTY.
  - FULL + m_axis_tready → ONE: the skid beat moves to the output.
  - ONE + accepted beat + m_axis_tready → ONE: the new beat replaces the output.
- Ordering: beats leave in acceptance order; none are dropped or duplicated.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, m_axis_tid=0, skid valid=0, ready_int_reg=0.
  - Because ready_int_reg=0, all s_axis_tready are 0 for the first cycle after rst deasserts.
- Latency: a beat accepted on edge N appears on m_axis at N+1 when the output is empty.
- Throughput: one beat per cycle sustained while m_axis_tready=1.
- Packet switch: the last beat is accepted and acknowledged at edge N, the arbiter updates its grant at N+1, and a different port's first beat can be accepted at N+1. There is no bubble between packets.
- Backpressure: m_axis_tready low for k cycles lets at most one extra beat enter (into the skid). s_axis_tready drops one cycle after the skid fills.
- Reset mid-packet: the output and skid beats are discarded and no tlast is emitted. Recovering the truncated packet is the upstream's responsibility.
- Simultaneous events:
  - Grant changes while the output is FULL: no input beat is accepted until ready_int_reg returns.
  - m_axis_tready rises in the same cycle as an input accept: both take effect (ONE→ONE case).

## Structure
- Shared package/header constant: CL_S_COUNT helper ($clog2 wrapper). No other typedefs.
- One sub-module: tinyml_axis_skid_reg, the output register + skid buffer, parameterised on the payload width (DATA_WIDTH+KEEP_WIDTH+1+CL_S_COUNT).
- Top level: input mux, ready/acknowledge logic, and the skid instance.

## Test plan
- Single port, no backpressure: port 2 sends 4-beat packet 0xA0..0xA3, m_axis_tready=1 → m_axis carries 0xA0..0xA3 on consecutive cycles, tid=2, tlast on 0xA3, and arb_acknowledge[2] pulses once.
- Back-to-back switch: ports 0 and 1 each send a 3-beat packet, with the grant moving 0→1 after ack → 6 consecutive output beats with no gap, tid 0,0,0,1,1,1, and packets not interleaved.
- Backpressure: m_axis_tready=0 for 5 cycles mid-packet → exactly one beat is held in the skid, s_axis_tready goes low, and the beat order is preserved after release.
- No grant: arb_grant_valid=0 with all tvalid=1 for 10 cycles → s_axis_tready=0, m_axis_tvalid=0, and arb_request=4'b1111.
- Reset mid-packet: rst asserted on beat 2 of a 5-beat packet → m_axis_tvalid=0 next cycle and all outputs match their reset values.
- Random: 1000 packets with random tvalid/tready and a round-robin arbiter model → the scoreboard sees every packet intact, in per-port order, with correct tid.
